regfile_sec: RTL

Parametrised, secured general-purpose register file for the RISC-V core. It replaces the fixed 32×32 register array with a configurable XLEN × NREGS file and offers:

- two registered read ports, a dedicated store-data read port, and separate ALU and load write ports;
- hardware zeroing of all registers after reset;
- a lockable key register that drives `key_access` to the crypto/security unit.

It sits between decode/ALU writeback/load unit and the memory stage.

---
 rtl/regfile_sec_pkg.sv | 13 +
 rtl/regfile_sec_if.sv | 43 ++++
 rtl/regfile_sec_rdport.sv | 64 ++++++
 rtl/regfile_sec.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/regfile_sec_pkg.sv
// Shared types and default parameter values for the secured register file.
package regfile_sec_pkg;

    typedef enum logic [0:0] {
        SCRUB,
        RUN
    } rf_state_e;

    localparam int unsigned XLEN_D    = 32;
    localparam int unsigned NREGS_D   = 32;
    localparam logic [15:0] KEY_RST_D = 16'h0032;

endpackage

// File: rtl/regfile_sec_if.sv
// Request/response bundle of the register file: read, write, store-data and key signals.
interface regfile_sec_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned KEY_W = 16
);
    logic             ready;
    logic             rd_en;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             rd_valid;
    logic             alu_we;
    logic [AW-1:0]    alu_waddr;
    logic [XLEN-1:0]  alu_wdata;
    logic             ld_we;
    logic [AW-1:0]    ld_waddr;
    logic [XLEN-1:0]  ld_wdata;
    logic             st_en;
    logic [AW-1:0]    st_addr;
    logic [XLEN-1:0]  st_data;
    logic             st_valid;
    logic             key_lock;
    logic [KEY_W-1:0] key_access;
    logic             key_locked;
    logic             key_viol;

    modport master (
        output rd_en, rs1_addr, rs2_addr, alu_we, alu_waddr, alu_wdata,
               ld_we, ld_waddr, ld_wdata, st_en, st_addr, key_lock,
        input  ready, rs1_data, rs2_data, rd_valid, st_data, st_valid,
               key_access, key_locked, key_viol
    );

    modport slave (
        input  rd_en, rs1_addr, rs2_addr, alu_we, alu_waddr, alu_wdata,
               ld_we, ld_waddr, ld_wdata, st_en, st_addr, key_lock,
        output ready, rs1_data, rs2_data, rd_valid, st_data, st_valid,
               key_access, key_locked, key_viol
    );

endinterface

// File: rtl/regfile_sec_rdport.sv
// One registered read port with x0 / locked-key masking.
// Same-cycle write forwarding is compiled in when RF_BYPASS_EN is defined.
module regfile_sec_rdport #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned KEY_IDX = 31
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            locked_i,
    input  logic            alu_wr_i,
    input  logic [AW-1:0]   alu_waddr_i,
    input  logic [XLEN-1:0] alu_wdata_i,
    input  logic            ld_wr_i,
    input  logic [AW-1:0]   ld_waddr_i,
    input  logic [XLEN-1:0] ld_wdata_i,
    output logic [XLEN-1:0] data_o
);

    localparam logic [AW-1:0] KeyAddr = AW'(KEY_IDX);

    logic [XLEN-1:0] data_q, data_d, fwd;

`ifdef RF_BYPASS_EN
    // Write strobes are already qualified, so load-before-ALU gives load-wins priority.
    always_comb begin
        fwd = mem_rdata_i;
        if (ld_wr_i && ld_waddr_i == addr_i) begin
            fwd = ld_wdata_i;
        end else if (alu_wr_i && alu_waddr_i == addr_i) begin
            fwd = alu_wdata_i;
        end
    end
`else
    logic unused_bypass;
    assign fwd = mem_rdata_i;
    assign unused_bypass = ^{alu_wr_i, alu_waddr_i, alu_wdata_i, ld_wr_i, ld_waddr_i, ld_wdata_i};
`endif

    always_comb begin
        data_d = data_q;
        if (en_i) begin
            if (addr_i == '0 || (locked_i && addr_i == KeyAddr)) begin
                data_d = '0;
            end else begin
                data_d = fwd;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/regfile_sec.sv
// Secured XLEN x NREGS register file: post-reset scrub, dual write ports, lockable key shadow.
// Optional same-cycle write-to-read forwarding via RF_BYPASS_EN.
module regfile_sec
    import regfile_sec_pkg::*;
#(
    parameter int unsigned      XLEN    = XLEN_D,
    parameter int unsigned      NREGS   = NREGS_D,
    parameter int unsigned      KEY_W   = 16,
    parameter int unsigned      KEY_IDX = 31,
    parameter logic [KEY_W-1:0] KEY_RST = KEY_W'(KEY_RST_D)
) (
    input logic          clk,
    input logic          rst_n,
    regfile_sec_if.slave bus
);

    localparam int unsigned   AW      = $clog2(NREGS);
    localparam logic [AW-1:0] KeyAddr = AW'(KEY_IDX);
    localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

    rf_state_e        state_q, state_d;
    logic [AW-1:0]    scrub_cnt_q, scrub_cnt_d;
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [KEY_W-1:0] key_q, key_d;
    logic             locked_q, locked_d;
    logic             viol_q, viol_d;
    logic             rd_valid_q, rd_valid_d;
    logic             st_valid_q, st_valid_d;

    logic run, alu_hit_key, ld_hit_key, alu_ok, ld_ok;
    logic [XLEN-1:0] rs1_data, rs2_data, st_data;

    assign run         = (state_q == RUN);
    assign alu_hit_key = bus.alu_we && bus.alu_waddr == KeyAddr;
    assign ld_hit_key  = bus.ld_we && bus.ld_waddr == KeyAddr;

    // Accepted writes: RUN only, never x0, never the key slot once locked; load wins collisions.
    assign ld_ok  = run && bus.ld_we && bus.ld_waddr != '0 && !(locked_q && ld_hit_key);
    assign alu_ok = run && bus.alu_we && bus.alu_waddr != '0 && !(locked_q && alu_hit_key) &&
                    !(bus.ld_we && bus.ld_waddr == bus.alu_waddr);

    always_comb begin
        state_d     = state_q;
        scrub_cnt_d = scrub_cnt_q;
        if (state_q == SCRUB) begin
            scrub_cnt_d = scrub_cnt_q + 1'b1;
            if (scrub_cnt_q == LastIdx) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        key_d = key_q;
        if (ld_ok && bus.ld_waddr == KeyAddr) begin
            key_d = bus.ld_wdata[KEY_W-1:0];
        end else if (alu_ok && bus.alu_waddr == KeyAddr) begin
            key_d = bus.alu_wdata[KEY_W-1:0];
        end
        locked_d   = locked_q | (run & bus.key_lock);
        viol_d     = run && locked_q && (alu_hit_key || ld_hit_key);
        rd_valid_d = run && bus.rd_en;
        st_valid_d = run && bus.st_en;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SCRUB;
            scrub_cnt_q <= '0;
            key_q       <= KEY_RST;
            locked_q    <= 1'b0;
            viol_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            st_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            scrub_cnt_q <= scrub_cnt_d;
            key_q       <= key_d;
            locked_q    <= locked_d;
            viol_q      <= viol_d;
            rd_valid_q  <= rd_valid_d;
            st_valid_q  <= st_valid_d;
        end
    end

    // Storage is not reset; the scrub pass clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (!run) begin
                regs_q[scrub_cnt_q] <= '0;
            end else begin
                if (alu_ok) begin
                    regs_q[bus.alu_waddr] <= bus.alu_wdata;
                end
                if (ld_ok) begin
                    regs_q[bus.ld_waddr] <= bus.ld_wdata;
                end
            end
        end
    end

    regfile_sec_rdport #(
        .XLEN    (XLEN),
        .AW      (AW),
        .KEY_IDX (KEY_IDX)
    ) u_rd_rs1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (run && bus.rd_en),
        .addr_i      (bus.rs1_addr),
        .mem_rdata_i (regs_q[bus.rs1_addr]),
        .locked_i    (locked_q),
        .alu_wr_i    (alu_ok),
        .alu_waddr_i (bus.alu_waddr),
        .alu_wdata_i (bus.alu_wdata),
        .ld_wr_i     (ld_ok),
        .ld_waddr_i  (bus.ld_waddr),
        .ld_wdata_i  (bus.ld_wdata),
        .data_o      (rs1_data)
    );

    regfile_sec_rdport #(
        .XLEN    (XLEN),
        .AW      (AW),
        .KEY_IDX (KEY_IDX)
    ) u_rd_rs2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (run && bus.rd_en),
        .addr_i      (bus.rs2_addr),
        .mem_rdata_i (regs_q[bus.rs2_addr]),
        .locked_i    (locked_q),
        .alu_wr_i    (alu_ok),
        .alu_waddr_i (bus.alu_waddr),
        .alu_wdata_i (bus.alu_wdata),
        .ld_wr_i     (ld_ok),
        .ld_waddr_i  (bus.ld_waddr),
        .ld_wdata_i  (bus.ld_wdata),
        .data_o      (rs2_data)
    );

    regfile_sec_rdport #(
        .XLEN    (XLEN),
        .AW      (AW),
        .KEY_IDX (KEY_IDX)
    ) u_rd_st (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (run && bus.st_en),
        .addr_i      (bus.st_addr),
        .mem_rdata_i (regs_q[bus.st_addr]),
        .locked_i    (locked_q),
        .alu_wr_i    (alu_ok),
        .alu_waddr_i (bus.alu_waddr),
        .alu_wdata_i (bus.alu_wdata),
        .ld_wr_i     (ld_ok),
        .ld_waddr_i  (bus.ld_waddr),
        .ld_wdata_i  (bus.ld_wdata),
        .data_o      (st_data)
    );

    assign bus.ready      = run;
    assign bus.rs1_data   = rs1_data;
    assign bus.rs2_data   = rs2_data;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.st_data    = st_data;
    assign bus.st_valid   = st_valid_q;
    assign bus.key_access = key_q;
    assign bus.key_locked = locked_q;
    assign bus.key_viol   = viol_q;

endmodule
